keccak_arb_ctrl: RTL and testbench

KECCAK_ARB_CTRL -- requirements
Module: keccak_arb_ctrl

---
 rtl/keccak_arb_ctrl.sv | 151 +++++++++++++++
 tb/tb_keccak_arb_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arb_ctrl.sv
// Two-requester arbiter and message sequencer in front of a Keccak core.
// A granted requester streams 64-bit words; the block adds the final-word
// markers or a pad-only word, waits for the digest, captures it and signals done.
`timescale 1ns/1ps
module keccak_arb_ctrl #(
    parameter int D = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic [15:0]  len0,
    input  logic [15:0]  len1,
    input  logic [63:0]  wdata0,
    input  logic [63:0]  wdata1,
    input  logic [1:0]   wvalid,
    output logic [1:0]   wready,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [D-1:0] digest,
    output logic         core_reset,
    output logic [63:0]  core_in,
    output logic         core_in_ready,
    output logic         core_is_last,
    output logic [2:0]   core_byte_num,
    input  logic         core_buffer_full,
    input  logic [D-1:0] core_out,
    input  logic         core_out_ready
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, PAD, WAIT, DONE} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     gnt_reg, gnt_next;
    logic           prio_reg, prio_next;   // requester that wins the next tie
    logic [12:0]    cnt_reg, cnt_next;     // words remaining minus one
    logic [D-1:0]   digest_reg;
    logic           win;

    logic [15:0]    len_sel;
    logic [63:0]    wdata_sel;
    logic           wvalid_sel;

    // Everything after the grant is steered by the single registered grant bit.
    assign len_sel    = gnt_reg[1] ? len1   : len0;
    assign wdata_sel  = gnt_reg[1] ? wdata1 : wdata0;
    assign wvalid_sel = gnt_reg[1] ? wvalid[1] : wvalid[0];

    assign gnt    = gnt_reg;
    assign digest = digest_reg;

    // Per-requester handshake and completion strobes, gated by the grant.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign wready[gi] = (state_reg == FEED) && gnt_reg[gi] && !core_buffer_full;
            assign done[gi]   = (state_reg == DONE) && gnt_reg[gi];
        end
    endgenerate

    // State, grant, round-robin pointer and word counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            gnt_reg   <= 2'b00;
            prio_reg  <= 1'b0;
            cnt_reg   <= 13'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            prio_reg  <= prio_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Digest capture when the core reports completion; held until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digest_reg <= '0;
        end else if (state_reg == WAIT && core_out_ready) begin
            digest_reg <= core_out;
        end
    end

    // Next-state logic and core-side outputs.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        prio_next     = prio_reg;
        cnt_next      = cnt_reg;
        win           = 1'b0;
        core_reset    = 1'b0;
        core_in       = 64'd0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = 3'd0;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    win        = (req == 2'b11) ? prio_reg : req[1];
                    gnt_next   = win ? 2'b10 : 2'b01;
                    prio_next  = ~win;
                    state_next = CLR;
                end
            end
            CLR: begin
                core_reset = 1'b1;
                // Storing ceil(len/8)-1 lets 65535 bytes (8192 words) fit 13 bits;
                // the wrapped value for len==0 is never used since that goes to PAD.
                cnt_next   = len_sel[15:3] - {12'd0, ~|len_sel[2:0]};
                state_next = (len_sel != 16'd0) ? FEED : PAD;
            end
            FEED: begin
                if (wvalid_sel && !core_buffer_full) begin
                    core_in_ready = 1'b1;
                    core_in       = wdata_sel;
                    if (cnt_reg == 13'd0) begin
                        if (len_sel[2:0] != 3'd0) begin
                            core_is_last  = 1'b1;
                            core_byte_num = len_sel[2:0];
                            state_next    = WAIT;
                        end else begin
                            state_next = PAD;
                        end
                    end else begin
                        cnt_next = cnt_reg - 13'd1;
                    end
                end
            end
            PAD: begin
                // Whole-word messages need an empty final block to carry the padding.
                if (!core_buffer_full) begin
                    core_in_ready = 1'b1;
                    core_is_last  = 1'b1;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                if (core_out_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                gnt_next   = 2'b00;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_keccak_arb_ctrl.sv
// Bench for keccak_arb_ctrl: a behavioural core responder returns known SHA3-256
// digests; expected core transfers are queued as stimulus is prepared and
// compared against the transfers the core side actually received.
`timescale 1ns/1ps
module tb_keccak_arb_ctrl;
    localparam int D = 256;
    localparam logic [D-1:0] DIG_FOX   = 256'h69070dda01975c8c120c3aada1b282394e7f032fa9cf32f4cb2259a0897dfc04;
    localparam logic [D-1:0] DIG_W8    = 256'he44f5c3922ae49c92be921b4c3fd73a0b940f9fa6f825d6e660d5938cc0d691f;
    localparam logic [D-1:0] DIG_EMPTY = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   req;
    logic [15:0]  len0, len1;
    logic [63:0]  wdata0, wdata1;
    logic [1:0]   wvalid;
    logic [1:0]   wready, gnt, done;
    logic [D-1:0] digest;
    logic         core_reset, core_in_ready, core_is_last;
    logic [63:0]  core_in;
    logic [2:0]   core_byte_num;
    logic         bf;
    logic [D-1:0] core_out = '0;
    logic         core_out_ready = 1'b0;

    always #5 clk = ~clk;

    keccak_arb_ctrl #(.D(D)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .len0(len0), .len1(len1),
        .wdata0(wdata0), .wdata1(wdata1), .wvalid(wvalid), .wready(wready),
        .gnt(gnt), .done(done), .digest(digest), .core_reset(core_reset),
        .core_in(core_in), .core_in_ready(core_in_ready), .core_is_last(core_is_last),
        .core_byte_num(core_byte_num), .core_buffer_full(bf), .core_out(core_out),
        .core_out_ready(core_out_ready)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  bn;
    } xfer_t;

    int errors = 0;
    int checks = 0;
    xfer_t exp_q[$];
    xfer_t obs_q[$];
    logic [7:0]  msg_q[$];
    logic [63:0] words[$];
    int core_reset_cnt = 0, wready_cnt = 0, viol_cnt = 0, overlap_cnt = 0;
    int lat = 0;
    logic [D-1:0] cur_digest, last_digest;

    // Core-side monitor: records every transfer and counts protocol events.
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_in_ready) obs_q.push_back({core_in, core_is_last, core_byte_num});
            if (core_reset) core_reset_cnt <= core_reset_cnt + 1;
            if (wready != 2'b00) wready_cnt <= wready_cnt + 1;
            if (core_in_ready && bf) viol_cnt <= viol_cnt + 1;
            if (done == 2'b11) overlap_cnt <= overlap_cnt + 1;
        end
    end

    // Core responder: digest becomes ready a few cycles after the last block.
    always @(negedge clk) begin
        core_out_ready <= 1'b0;
        core_out       <= '0;
        if (!reset_n || core_reset) begin
            lat <= 0;
        end else if (core_in_ready && core_is_last) begin
            lat <= 3;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                core_out_ready <= 1'b1;
                core_out       <= cur_digest;
            end
        end
    end

    task automatic load_fox();
        string s;
        s = "The quick brown fox jumps over the lazy dog";
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_word(input logic [63:0] w);
        msg_q.delete();
        for (int k = 0; k < 8; k++) msg_q.push_back(w[63-8*k -: 8]);
    endtask

    // Split the message into big-endian words and queue the expected core transfers.
    task automatic prep(input int len);
        int nw;
        xfer_t e;
        logic [63:0] v;
        nw = (len + 7) / 8;
        words.delete();
        for (int w = 0; w < nw; w++) begin
            v = '0;
            for (int k = 0; k < 8; k++)
                if (8*w + k < len) v[63-8*k -: 8] = msg_q[8*w + k];
            words.push_back(v);
            e.data = v;
            e.last = (w == nw - 1) && (len % 8 != 0);
            e.bn   = (w == nw - 1) ? 3'(len % 8) : 3'd0;
            exp_q.push_back(e);
        end
        if (len % 8 == 0) begin
            e.data = 64'd0; e.last = 1'b1; e.bn = 3'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 2'b00; wvalid = 2'b00; bf = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || wready !== 2'b00) begin
            errors++; $display("FAIL reset_handshake: gnt=%b done=%b wready=%b required 00", gnt, done, wready);
        end
        checks++;
        if (digest !== '0) begin
            errors++; $display("FAIL reset_digest: got %h required 0", digest);
        end
        checks++;
        if ({core_reset, core_in_ready, core_is_last, core_byte_num, core_in} !== '0) begin
            errors++; $display("FAIL reset_core: rst=%b rdy=%b last=%b bn=%0d in=%h required all 0",
                               core_reset, core_in_ready, core_is_last, core_byte_num, core_in);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        last_digest = '0;
        $display("txn reset released");
    endtask

    task automatic start_req(input int p, input string name);
        int g;
        logic [1:0] ex;
        ex = (p == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        req[p] = 1'b1;
        g = 0;
        while (gnt == 2'b00 && g < 20) begin
            @(posedge clk); #1; g++;
        end
        req[p] = 1'b0;  // dropping the request after grant must not abort the message
        checks++;
        if (gnt !== ex) begin
            errors++; $display("FAIL %s grant: got %b required %b", name, gnt, ex);
        end
        checks++;
        if (digest !== last_digest) begin
            errors++; $display("FAIL %s digest_held: got %h required %h", name, digest, last_digest);
        end
    endtask

    task automatic feed(input int p, input int stall_at, input int nmax, input string name);
        int i, g, stall_left;
        i = 0; g = 0; stall_left = 5;
        while (i < nmax && g < 2000) begin
            if (i == stall_at && stall_left > 0) begin
                bf = 1'b1; stall_left--;
            end else begin
                bf = 1'b0;
            end
            wvalid[p] = 1'b1;
            if (p == 0) wdata0 = words[i]; else wdata1 = words[i];
            @(negedge clk);
            if (bf) begin
                checks++;
                if (wready !== 2'b00) begin
                    errors++; $display("FAIL %s stall_wready: got %b required 00", name, wready);
                end
                checks++;
                if (core_in_ready !== 1'b0) begin
                    errors++; $display("FAIL %s stall_core_in_ready: got %b required 0", name, core_in_ready);
                end
            end else if (wready[p]) begin
                i++;
            end
            @(posedge clk); #1; g++;
        end
        checks++;
        if (i != nmax) begin
            errors++; $display("FAIL %s feed_timeout: accepted %0d words required %0d", name, i, nmax);
        end
        wvalid[p] = 1'b0; bf = 1'b0;
    endtask

    task automatic wait_done(input int p, input string name);
        int g;
        logic [1:0] ex;
        ex = (p == 0) ? 2'b01 : 2'b10;
        g = 0;
        @(negedge clk);
        while (done == 2'b00 && g < 500) begin
            @(negedge clk); g++;
        end
        checks++;
        if (done !== ex) begin
            errors++; $display("FAIL %s done: got %b required %b", name, done, ex);
        end
        checks++;
        if (digest !== cur_digest) begin
            errors++; $display("FAIL %s digest: got %h required %h", name, digest, cur_digest);
        end
        @(negedge clk);
        checks++;
        if (done !== 2'b00 || gnt !== 2'b00) begin
            errors++; $display("FAIL %s done_release: done=%b gnt=%b required 00 00", name, done, gnt);
        end
    endtask

    task automatic compare_xfers(input string name);
        xfer_t e, o;
        int n;
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s xfer_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        n = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL %s xfer%0d: got data=%h last=%b bn=%0d required data=%h last=%b bn=%0d",
                                   name, n, o.data, o.last, o.bn, e.data, e.last, e.bn);
            end
            n++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic run_txn(input int p, input int len, input logic [D-1:0] dig,
                           input int stall_at, input string name);
        int crc, vic, wrc;
        crc = core_reset_cnt; vic = viol_cnt; wrc = wready_cnt;
        prep(len);
        cur_digest = dig;
        if (p == 0) len0 = 16'(len); else len1 = 16'(len);
        start_req(p, name);
        feed(p, stall_at, words.size(), name);
        wait_done(p, name);
        compare_xfers(name);
        checks++;
        if (core_reset_cnt - crc != 1) begin
            errors++; $display("FAIL %s core_reset_cycles: got %0d required 1", name, core_reset_cnt - crc);
        end
        checks++;
        if (viol_cnt != vic) begin
            errors++; $display("FAIL %s ready_while_full: got %0d required 0", name, viol_cnt - vic);
        end
        if (len == 0) begin
            checks++;
            if (wready_cnt != wrc) begin
                errors++; $display("FAIL %s wready_len0: got %0d cycles required 0", name, wready_cnt - wrc);
            end
        end
        last_digest = dig;
        $display("txn %s port=%0d len=%0d words=%0d digest=%h", name, p, len, words.size(), digest);
    endtask

    task automatic test_fox();
        load_fox();
        run_txn(0, 43, DIG_FOX, -1, "fox_p0");
    endtask

    task automatic test_len8();
        load_word(64'hc20634f357f421fb);
        run_txn(1, 8, DIG_W8, -1, "len8_p1");
    endtask

    task automatic test_len0();
        msg_q.delete();
        run_txn(0, 0, DIG_EMPTY, -1, "len0_p0");
    endtask

    task automatic test_stall();
        load_fox();
        run_txn(1, 43, DIG_FOX, 2, "stall_p1");
    endtask

    task automatic test_round_robin();
        logic [1:0] order[$];
        logic [1:0] exp_order [3];
        int ov, crc, g;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
        test_reset();
        len0 = 16'd0; len1 = 16'd0;
        cur_digest = DIG_EMPTY;
        msg_q.delete();
        for (int k = 0; k < 3; k++) prep(0);
        ov = overlap_cnt; crc = core_reset_cnt;
        @(posedge clk); #1;
        req = 2'b11;
        g = 0;
        while (order.size() < 3 && g < 300) begin
            @(negedge clk);
            if (done != 2'b00) order.push_back(done);
            @(posedge clk); #1;
            if (order.size() >= 2 && gnt != 2'b00) req = 2'b00;
            g++;
        end
        req = 2'b00;
        repeat (3) @(posedge clk);
        checks++;
        if (order.size() != 3) begin
            errors++; $display("FAIL rr_done_count: got %0d required 3", order.size());
        end
        for (int k = 0; k < 3 && k < order.size(); k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                errors++; $display("FAIL rr_order%0d: got %b required %b", k, order[k], exp_order[k]);
            end
        end
        checks++;
        if (overlap_cnt != ov) begin
            errors++; $display("FAIL rr_done_overlap: got %0d required 0", overlap_cnt - ov);
        end
        checks++;
        if (core_reset_cnt - crc != 3) begin
            errors++; $display("FAIL rr_core_reset: got %0d required 3", core_reset_cnt - crc);
        end
        checks++;
        if (digest !== DIG_EMPTY) begin
            errors++; $display("FAIL rr_digest: got %h required %h", digest, DIG_EMPTY);
        end
        compare_xfers("rr");
        last_digest = DIG_EMPTY;
        $display("txn round_robin grants=%0d", order.size());
    endtask

    task automatic test_reset_mid_feed();
        load_fox();
        prep(43);
        len0 = 16'd43;
        cur_digest = DIG_FOX;
        start_req(0, "abort");
        feed(0, -1, 3, "abort");
        wvalid[0] = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, wready, core_reset, core_in_ready, core_is_last, core_byte_num, core_in} !== '0) begin
            errors++; $display("FAIL abort_outputs: gnt=%b done=%b wready=%b rst=%b rdy=%b last=%b bn=%0d in=%h required all 0",
                               gnt, done, wready, core_reset, core_in_ready, core_is_last, core_byte_num, core_in);
        end
        checks++;
        if (digest !== '0) begin
            errors++; $display("FAIL abort_digest: got %h required 0", digest);
        end
        wvalid = 2'b00; req = 2'b00;
        exp_q.delete(); obs_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        last_digest = '0;
        $display("txn abort after 3 words");
        run_txn(0, 43, DIG_FOX, -1, "rerun_p0");
    endtask

    initial begin
        reset_n = 1'b0; req = 2'b00; wvalid = 2'b00; bf = 1'b0;
        len0 = 16'd0; len1 = 16'd0; wdata0 = 64'd0; wdata1 = 64'd0;
        cur_digest = '0; last_digest = '0;
        test_reset();
        test_fox();
        test_len8();
        test_len0();
        test_stall();
        test_round_robin();
        test_reset_mid_feed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
